mig_eval_seq: RTL

MIG_EVAL_SEQ -- requirements
Module: mig_eval_seq

---
 rtl/mig_eval_seq_if.sv | 40 ++++
 rtl/mig_eval_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mig_eval_seq_if.sv
// Handshake and configuration bundle for the majority-inverter-graph evaluator.
// The master side drives configuration, input vectors and the result-ready signal.
// The slave side (the evaluator) returns in_ready, the result and cfg_err.
interface mig_eval_seq_if #(
  parameter int NIN    = 7,
  parameter int NNODES = 8
);
  localparam int SELW = $clog2(NIN + NNODES + 1);
  localparam int AW   = $clog2(NNODES);
  localparam int LW   = $clog2(NNODES + 1);
  localparam int CW   = 3 * SELW + 3;

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_len_we;
  logic [LW-1:0] cfg_len;
  logic          cfg_oinv;
  logic          cfg_err;

  logic           in_valid;
  logic           in_ready;
  logic [NIN-1:0] in_x;

  logic out_valid;
  logic out_ready;
  logic out_bit;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len, cfg_oinv,
    output in_valid, in_x, out_ready,
    input  cfg_err, in_ready, out_valid, out_bit
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len, cfg_oinv,
    input  in_valid, in_x, out_ready,
    output cfg_err, in_ready, out_valid, out_bit
  );
endinterface

// File: rtl/mig_eval_seq.sv
// Sequential majority-inverter-graph evaluator.
// A small program of majority nodes is loaded while idle.  Each accepted input
// vector is then evaluated one node per clock, and the last node
// (optionally inverted) is returned over a valid/ready handshake.
module mig_eval_seq #(
  parameter int NIN    = 7,
  parameter int NNODES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mig_eval_seq_if.slave  bus
);
  localparam int SELW = $clog2(NIN + NNODES + 1);
  localparam int AW   = $clog2(NNODES);
  localparam int LW   = $clog2(NNODES + 1);
  localparam int CW   = 3 * SELW + 3;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t            state_q;
  logic [AW-1:0]     ptr_q;
  logic [LW-1:0]     len_q;
  logic              oinv_q;
  logic [CW-1:0]     prog_q [NNODES];
  logic [NNODES-1:0] node_q;
  logic [NIN-1:0]    x_q;
  logic              out_valid_q;
  logic              out_bit_q;
  logic              cfg_err_q;

  logic          cfg_any;
  logic          in_ready;
  logic [CW-1:0] entry;
  logic          op_a, op_b, op_c, maj;
  logic [LW-1:0] len_m1;
  logic          last;
  logic          final_bit;
  logic [LW-1:0] len_clamp;
  logic          addr_ok;

  // Operand index: 0 is constant 0, then primary inputs, then nodes; anything past is 0.
  function automatic logic pick(input logic [SELW-1:0] sel,
                                input logic [NIN-1:0] xv,
                                input logic [NNODES-1:0] nv);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NIN; k++)
      if (int'(sel) == k + 1) r = xv[k];
    for (int k = 0; k < NNODES; k++)
      if (int'(sel) == NIN + 1 + k) r = nv[k];
    return r;
  endfunction

  assign cfg_any       = bus.cfg_we | bus.cfg_len_we;
  assign in_ready      = (state_q == IDLE) && !cfg_any;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.cfg_err   = cfg_err_q;

  // Majority of the node under the pointer, plus decoded config and result helpers.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    entry     = prog_q[ptr_q];
    op_a      = pick(entry[SELW-1:0],        x_q, node_q) ^ entry[3*SELW];
    op_b      = pick(entry[2*SELW-1:SELW],   x_q, node_q) ^ entry[3*SELW+1];
    op_c      = pick(entry[3*SELW-1:2*SELW], x_q, node_q) ^ entry[3*SELW+2];
    maj       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    len_m1    = len_q - 1'b1;
    last      = (LW'(ptr_q) == len_m1);
    final_bit = (len_q == '0) ? oinv_q : (node_q[len_m1[AW-1:0]] ^ oinv_q);
    len_clamp = (int'(bus.cfg_len) > NNODES) ? LW'(NNODES) : bus.cfg_len;
    addr_ok   = (int'(bus.cfg_addr) < NNODES);
  end

  // Control FSM, program store, node registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      oinv_q      <= 1'b0;
      node_q      <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      // NOTE: the program store is reset on purpose: after reset it must read as an empty program.
      for (int i = 0; i < NNODES; i++) prog_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_we) begin
            if (addr_ok) prog_q[bus.cfg_addr] <= bus.cfg_data;
            else         cfg_err_q <= 1'b1;
          end
          if (bus.cfg_len_we) begin
            len_q  <= len_clamp;
            oinv_q <= bus.cfg_oinv;
          end
          if (bus.in_valid && in_ready) begin
            x_q     <= bus.in_x;
            node_q  <= '0;
            ptr_q   <= '0;
            state_q <= (len_q != '0) ? EVAL : DONE;
          end
        end
        EVAL: begin
          if (cfg_any) cfg_err_q <= 1'b1;
          node_q[ptr_q] <= maj;
          if (last) state_q <= DONE;
          else      ptr_q   <= ptr_q + 1'b1;
        end
        DONE: begin
          if (cfg_any) cfg_err_q <= 1'b1;
          // The first DONE cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_bit_q   <= final_bit;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
